char_dev_ctrl: RTL and testbench
================================

Name: char_dev_ctrl

Overview:
- Parametrised multi-channel character-device controller, successor to the single keyboard/screen driver.
- Each channel has:
  - an RX FIFO (device -> CPU, e.g. keyboard);
  - a TX FIFO (CPU -> device, e.g. screen);
  - a CSR and a DR, both memory-mapped on an 8-bit device bus.
- Sits between the CPU device-bus decoder and the per-channel peripherals.
- Produces per-channel interrupt requests.

Parameters:
- NCH, 2: number of channels (1..8).
- DEPTH, 4: entries per RX and TX FIFO; power of two, >= 2.
- ADDR_W, 4: bus address width; must be >= clog2(NCH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_addr  in  ADDR_W  register address.
  - addr[0]: 0 = CSR, 1 = DR.
  - addr[ADDR_W-1:1] = channel number.
- bus_rd  in  1  read strobe, one cycle.
- bus_wr  in  1  write strobe, one cycle.
- bus_wdata  in  8  write data.
- bus_rdata  out  8  read data, registered.
- bus_ack  out  1  one-cycle pulse completing any access.
- dev_rx_valid  in  NCH  per-channel byte-present strobe from the device.
- dev_rx_data  in  NCH*8  device bytes; channel c at [8c+7:8c].
- dev_tx_valid  out  NCH  TX FIFO not empty.
- dev_tx_data  out  NCH*8  head of each TX FIFO.
- dev_tx_ready  in  NCH  device consumes the head byte when valid & ready.
- irq  out  NCH  per-channel interrupt request, level.

Behaviour:
- Reset (asynchronous, active-high):
  - all FIFOs empty;
  - CSR IE, OF and ERR bits = 0;
  - bus_rdata = 0x00, bus_ack = 0, irq = 0, dev_tx_valid = 0, dev_tx_data = 0x00.
  - Reset asserted mid-transfer discards all queued bytes; no partial state survives.
- CSR bit layout:
  - bit0 IE: rw.
  - bit1 RXA: RX FIFO non-empty, ro.
  - bit2 TXF: TX FIFO full, ro.
  - bit3 OF: RX overflow, sticky, write-1-to-clear.
  - bit4 ERR: bus error, sticky, write-1-to-clear.
  - bit5 TXE: TX FIFO empty, ro.
  - bits7:6: read 0.
  - A CSR write updates IE from wdata[0]; writing 1 to bit3 or bit4 clears that flag; other bits are ignored.
- Bus access:
  - A strobe in cycle N produces bus_ack and bus_rdata in cycle N+1.
  - A write returns rdata 0x00.
  - bus_rd and bus_wr high together: read served, write ignored.
  - Channel >= NCH: unmapped; ack still pulses, rdata = 0x00, no side effects.
- DR read:
  - pops the RX head and returns it;
  - RX empty: return 0x00, no pop, set ERR.
- DR write:
  - pushes wdata into TX;
  - TX full and no device pop in the same cycle: byte dropped, set ERR;
  - TX full with a device pop in the same cycle: accepted, count unchanged, no ERR.
- RX push:
  - dev_rx_valid high pushes dev_rx_data; there is no back-pressure, since keyboards cannot stall.
  - RX full and no CPU pop in the same cycle: byte dropped, set OF.
  - RX full with a CPU DR read in the same cycle: both occur, no OF.
- TX drain:
  - dev_tx_valid[c] = TX not empty;
  - dev_tx_data shows the head combinationally from FIFO storage;
  - pop on valid & ready; the next byte appears the following cycle.
- Push and pop on the same FIFO in the same cycle, with the FIFO non-empty and non-full: count unchanged.
- Pointers wrap modulo DEPTH; count is held as clog2(DEPTH)+1 bits to distinguish full from empty.
- Flag timing: RXA, TXF, TXE, OF and ERR are visible in a CSR read issued the cycle after the causing event.
- Interrupts:
  - irq[c] = IE & (RXA | OF), registered; asserts one cycle after the condition holds.
  - irq[c] deasserts one cycle after the condition clears, or after IE is cleared.
- Channels are fully independent; a bus access touches exactly one channel.

Decomposition:
- Package char_dev_pkg holds:
  - CSR bit indices: CSR_IE=0, CSR_RXA=1, CSR_TXF=2, CSR_OF=3, CSR_ERR=4, CSR_TXE=5;
  - REG_CSR=0, REG_DR=1.
- Sub-module sync_fifo is instantiated 2*NCH times inside a generate loop.
  - Parameters: WIDTH, DEPTH.
  - Signals: push, pop, din, dout, full, empty, count.
  - Reset is asynchronous, active-high.
- The top level holds only the bus decoder, flag logic and the irq registers.

Test Plan:
- Reset check: after rst, CSR read of ch0 (addr 0) -> rdata 0x20 (TXE only); irq = 0; dev_tx_valid = 0.
- TX path:
  - write 0x61 to addr 1 -> next cycle dev_tx_valid[0]=1 and dev_tx_data[7:0]=0x61;
  - hold dev_tx_ready[0]=1 for one cycle -> valid drops and CSR TXE=1.
- RX with interrupt:
  - write CSR ch1 (addr 2) = 0x01, then pulse dev_rx_valid[1] with 0x41 -> irq[1]=1;
  - DR read of addr 3 -> rdata 0x41, then irq[1]=0.
- RX overflow:
  - DEPTH=4; push 5 bytes 0x30..0x34 on ch0 -> CSR OF=1;
  - four DR reads -> 0x30..0x33; fifth read -> 0x00 with ERR=1;
  - write CSR 0x18 -> OF and ERR both clear.
- TX full:
  - dev_tx_ready=0; write 5 bytes -> TXF=1 after the 4th byte and ERR=1 after the 5th.
  - Then, with TX full again, assert dev_tx_ready and a write in the same cycle -> write accepted, ERR unchanged.
- Boundary:
  - access to addr 0xE with NCH=2 -> ack=1, rdata 0x00, no state change;
  - reset asserted with 3 bytes queued in TX -> dev_tx_valid=0 immediately.

Source files
------------

// File: rtl/char_dev_pkg.sv
// rtl/char_dev_pkg.sv - shared register map for the multi-channel character device controller
package char_dev_pkg;

  localparam int CSR_IE  = 0;
  localparam int CSR_RXA = 1;
  localparam int CSR_TXF = 2;
  localparam int CSR_OF  = 3;
  localparam int CSR_ERR = 4;
  localparam int CSR_TXE = 5;

  typedef enum logic {
    REG_CSR = 1'b0,
    REG_DR  = 1'b1
  } reg_sel_e;

endpackage

// File: rtl/char_dev_ctrl_if.sv
// rtl/char_dev_ctrl_if.sv - 8-bit device bus between the CPU decoder and the controller
interface char_dev_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd;
  logic              bus_wr;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_addr, bus_rd, bus_wr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_rd, bus_wr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push into a full FIFO succeeds only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is cleared too so the head reads 0x00 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/char_dev_ctrl.sv
// rtl/char_dev_ctrl.sv - multi-channel character device controller: bus decoder, CSR flags, irq
module char_dev_ctrl
  import char_dev_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  char_dev_ctrl_if.slave     bus,
  input  logic [NCH-1:0]     i_dev_rx_valid,
  input  logic [NCH*8-1:0]   i_dev_rx_data,
  output logic [NCH-1:0]     o_dev_tx_valid,
  output logic [NCH*8-1:0]   o_dev_tx_data,
  input  logic [NCH-1:0]     i_dev_tx_ready,
  output logic [NCH-1:0]     o_irq
);
  localparam int CH_W  = ADDR_W - 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CH_W-1:0]  w_ch;
  reg_sel_e         w_reg;
  logic             w_rd;
  logic             w_wr;
  logic [NCH-1:0]   w_sel;
  logic [NCH-1:0]   w_rx_pop;
  logic [NCH-1:0]   w_rx_full;
  logic [NCH-1:0]   w_rx_empty;
  logic [NCH-1:0]   w_rxa;
  logic [NCH-1:0]   w_tx_push;
  logic [NCH-1:0]   w_tx_pop;
  logic [NCH-1:0]   w_tx_full;
  logic [NCH-1:0]   w_tx_empty;
  logic [NCH-1:0]   w_csr_wr;
  logic [NCH-1:0]   w_of_set;
  logic [NCH-1:0]   w_err_set;
  logic [7:0]       w_rx_dout  [NCH];
  logic [7:0]       w_tx_dout  [NCH];
  logic [CNT_W-1:0] w_rx_count [NCH];
  logic [CNT_W-1:0] w_tx_count [NCH];
  logic [7:0]       w_csr      [NCH];
  logic [7:0]       w_rdata_nxt;

  logic [NCH-1:0]   r_ie;
  logic [NCH-1:0]   r_of;
  logic [NCH-1:0]   r_err;
  logic [NCH-1:0]   r_irq;
  logic [7:0]       r_rdata;
  logic             r_ack;

  // A simultaneous write is dropped so a combined strobe behaves as a pure read.
  assign w_ch  = bus.bus_addr[ADDR_W-1:1];
  assign w_reg = reg_sel_e'(bus.bus_addr[0]);
  assign w_rd  = bus.bus_rd;
  assign w_wr  = bus.bus_wr & ~bus.bus_rd;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0] w_csr_c;

    assign w_sel[c]     = (w_ch == CH_W'(c));
    assign w_rx_pop[c]  = w_rd & w_sel[c] & (w_reg == REG_DR) & ~w_rx_empty[c];
    assign w_tx_push[c] = w_wr & w_sel[c] & (w_reg == REG_DR);
    assign w_tx_pop[c]  = ~w_tx_empty[c] & i_dev_tx_ready[c];
    assign w_csr_wr[c]  = w_wr & w_sel[c] & (w_reg == REG_CSR);
    assign w_of_set[c]  = i_dev_rx_valid[c] & w_rx_full[c] & ~w_rx_pop[c];
    assign w_err_set[c] = (w_rd & w_sel[c] & (w_reg == REG_DR) & w_rx_empty[c])
                        | (w_tx_push[c] & w_tx_full[c] & ~w_tx_pop[c]);
    assign w_rxa[c]     = (w_rx_count[c] != '0);

    always_comb begin
      w_csr_c          = '0;
      w_csr_c[CSR_IE]  = r_ie[c];
      w_csr_c[CSR_RXA] = w_rxa[c];
      w_csr_c[CSR_TXF] = (w_tx_count[c] == CNT_W'(DEPTH));
      w_csr_c[CSR_OF]  = r_of[c];
      w_csr_c[CSR_ERR] = r_err[c];
      w_csr_c[CSR_TXE] = (w_tx_count[c] == '0);
    end
    assign w_csr[c] = w_csr_c;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i_dev_rx_valid[c]),
      .i_pop   (w_rx_pop[c]),
      .i_din   (i_dev_rx_data[8*c +: 8]),
      .o_dout  (w_rx_dout[c]),
      .o_full  (w_rx_full[c]),
      .o_empty (w_rx_empty[c]),
      .o_count (w_rx_count[c])
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_tx_push[c]),
      .i_pop   (w_tx_pop[c]),
      .i_din   (bus.bus_wdata),
      .o_dout  (w_tx_dout[c]),
      .o_full  (w_tx_full[c]),
      .o_empty (w_tx_empty[c]),
      .o_count (w_tx_count[c])
    );

    assign o_dev_tx_valid[c]       = ~w_tx_empty[c];
    assign o_dev_tx_data[8*c +: 8] = w_tx_dout[c];
  end

  // Unmapped channels match no w_sel bit, so they read 0x00 and touch nothing.
  always_comb begin
    w_rdata_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_rd && w_sel[c]) begin
        if (w_reg == REG_DR) begin
          w_rdata_nxt = w_rx_empty[c] ? 8'h00 : w_rx_dout[c];
        end else begin
          w_rdata_nxt = w_csr[c];
        end
      end
    end
  end

  // A flag being set in the same cycle as its write-1-to-clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ie    <= '0;
      r_of    <= '0;
      r_err   <= '0;
      r_irq   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack   <= bus.bus_rd | bus.bus_wr;
      r_rdata <= w_rdata_nxt;
      r_ie    <= (r_ie & ~w_csr_wr) | (w_csr_wr & {NCH{bus.bus_wdata[CSR_IE]}});
      r_of    <= (r_of & ~(w_csr_wr & {NCH{bus.bus_wdata[CSR_OF]}})) | w_of_set;
      r_err   <= (r_err & ~(w_csr_wr & {NCH{bus.bus_wdata[CSR_ERR]}})) | w_err_set;
      r_irq   <= r_ie & (w_rxa | r_of);
    end
  end

  assign bus.bus_rdata = r_rdata;
  assign bus.bus_ack   = r_ack;
  assign o_irq         = r_irq;
endmodule

// File: tb/tb_char_dev_ctrl.sv
// tb/tb_char_dev_ctrl.sv - scoreboard bench for char_dev_ctrl with a queue-based reference model
module tb_char_dev_ctrl;
  localparam int NCH    = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   dev_rx_valid;
  logic [NCH*8-1:0] dev_rx_data;
  logic [NCH-1:0]   dev_tx_valid;
  logic [NCH*8-1:0] dev_tx_data;
  logic [NCH-1:0]   dev_tx_ready;
  logic [NCH-1:0]   irq;

  char_dev_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  char_dev_ctrl #(.NCH(NCH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .i_dev_rx_valid (dev_rx_valid),
    .i_dev_rx_data  (dev_rx_data),
    .o_dev_tx_valid (dev_tx_valid),
    .o_dev_tx_data  (dev_tx_data),
    .i_dev_tx_ready (dev_tx_ready),
    .o_irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]     m_rx [NCH][$];
  logic [7:0]     m_tx [NCH][$];
  logic [NCH-1:0] m_ie, m_of, m_err, m_irq;
  logic [7:0]     exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] csr_of(input int c);
    return {2'b00, m_tx[c].size() == 0, m_err[c], m_of[c],
            m_tx[c].size() == DEPTH, m_rx[c].size() != 0, m_ie[c]};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_rx[c].delete();
      m_tx[c].delete();
    end
    m_ie = '0; m_of = '0; m_err = '0; m_irq = '0;
    exp_q.delete();
  endtask

  // Scoreboard monitor: every ack consumes the oldest expected read value.
  always @(negedge clk) begin
    if (bus.bus_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ack_unexpected: got ack with rdata 0x%0h, required no ack", bus.bus_rdata);
      end else begin
        chk("sb_rdata", 32'(bus.bus_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one cycle at a negedge, advance the model, then check device-side outputs.
  task automatic step(input bit rd, input bit wr, input logic [3:0] addr, input logic [7:0] wd,
                      input logic [NCH-1:0] rxv, input logic [NCH*8-1:0] rxd,
                      input logic [NCH-1:0] txr);
    int ch;
    bit dr, sel, do_wr, cpu_pop, dev_pop, of_set, err_set, tx_acc, is_csr_wr;
    int rx_n, tx_n;
    logic [7:0] exp;
    logic [NCH-1:0] nirq;
    logic [NCH-1:0] ev;

    bus.bus_rd = rd; bus.bus_wr = wr; bus.bus_addr = addr; bus.bus_wdata = wd;
    dev_rx_valid = rxv; dev_rx_data = rxd; dev_tx_ready = txr;

    ch = int'(addr[3:1]); dr = addr[0]; do_wr = wr && !rd; exp = 8'h00;
    for (int c = 0; c < NCH; c++) nirq[c] = m_ie[c] & ((m_rx[c].size() != 0) | m_of[c]);
    for (int c = 0; c < NCH; c++) begin
      sel = (ch == c); rx_n = m_rx[c].size(); tx_n = m_tx[c].size();
      cpu_pop = 0; of_set = 0; err_set = 0;
      dev_pop = (tx_n > 0) && txr[c];
      if (sel && rd && !dr) exp = csr_of(c);
      if (sel && rd && dr) begin
        if (rx_n > 0) begin exp = m_rx[c][0]; cpu_pop = 1; end
        else err_set = 1;
      end
      if (cpu_pop) void'(m_rx[c].pop_front());
      if (rxv[c]) begin
        if (rx_n == DEPTH && !cpu_pop) of_set = 1;
        else m_rx[c].push_back(rxd[8*c +: 8]);
      end
      tx_acc = sel && do_wr && dr && (tx_n < DEPTH || dev_pop);
      if (sel && do_wr && dr && !tx_acc) err_set = 1;
      if (dev_pop) void'(m_tx[c].pop_front());
      if (tx_acc) m_tx[c].push_back(wd);
      is_csr_wr = sel && do_wr && !dr;
      if (is_csr_wr) m_ie[c] = wd[0];
      m_of[c]  = (m_of[c]  & !(is_csr_wr && wd[3])) | of_set;
      m_err[c] = (m_err[c] & !(is_csr_wr && wd[4])) | err_set;
    end
    m_irq = nirq;
    if (rd || wr) exp_q.push_back(exp);

    @(negedge clk);
    for (int c = 0; c < NCH; c++) ev[c] = (m_tx[c].size() != 0);
    chk("tx_valid", 32'(dev_tx_valid), 32'(ev));
    chk("irq", 32'(irq), 32'(m_irq));
    for (int c = 0; c < NCH; c++)
      if (m_tx[c].size() != 0) chk("tx_data", 32'(dev_tx_data[8*c +: 8]), 32'(m_tx[c][0]));
  endtask

  task automatic rd_op(input logic [3:0] a);
    step(1'b1, 1'b0, a, 8'h00, '0, '0, '0);
  endtask
  task automatic wr_op(input logic [3:0] a, input logic [7:0] d, input logic [NCH-1:0] txr);
    step(1'b0, 1'b1, a, d, '0, '0, txr);
  endtask
  task automatic idle(input logic [NCH-1:0] rxv, input logic [NCH*8-1:0] rxd,
                      input logic [NCH-1:0] txr);
    step(1'b0, 1'b0, 4'h0, 8'h00, rxv, rxd, txr);
  endtask

  initial begin
    logic [3:0] a;
    logic [NCH-1:0] rv, tr;
    int op;

    rst = 1'b1;
    bus.bus_rd = 0; bus.bus_wr = 0; bus.bus_addr = '0; bus.bus_wdata = '0;
    dev_rx_valid = '0; dev_rx_data = '0; dev_tx_ready = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_tx_valid", 32'(dev_tx_valid), 32'h0);
    chk("rst_tx_data", 32'(dev_tx_data), 32'h0);
    chk("rst_ack", 32'(bus.bus_ack), 32'h0);

    rd_op(4'h0);
    chk("rst_csr0", 32'(bus.bus_rdata), 32'h20);

    wr_op(4'h1, 8'h61, '0);
    chk("tx_path_valid", 32'(dev_tx_valid[0]), 32'h1);
    chk("tx_path_data", 32'(dev_tx_data[7:0]), 32'h61);
    idle('0, '0, 2'b01);
    chk("tx_path_drain", 32'(dev_tx_valid[0]), 32'h0);
    rd_op(4'h0);
    chk("tx_path_txe", 32'(bus.bus_rdata), 32'h20);

    wr_op(4'h2, 8'h01, '0);
    idle(2'b10, 16'h4100, '0);
    idle('0, '0, '0);
    chk("rx_irq_set", 32'(irq[1]), 32'h1);
    rd_op(4'h3);
    chk("rx_dr1", 32'(bus.bus_rdata), 32'h41);
    idle('0, '0, '0);
    chk("rx_irq_clr", 32'(irq[1]), 32'h0);

    for (int i = 0; i < 5; i++) idle(2'b01, 16'(8'h30 + i), '0);
    rd_op(4'h0);
    chk("of_set", 32'(bus.bus_rdata[3]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd_op(4'h1);
      chk("of_dr", 32'(bus.bus_rdata), 32'(8'h30 + i));
    end
    rd_op(4'h1);
    chk("of_empty_dr", 32'(bus.bus_rdata), 32'h00);
    rd_op(4'h0);
    chk("of_err", 32'(bus.bus_rdata & 8'h18), 32'h18);
    wr_op(4'h0, 8'h18, '0);
    rd_op(4'h0);
    chk("of_w1c", 32'(bus.bus_rdata & 8'h18), 32'h00);

    for (int i = 0; i < 4; i++) wr_op(4'h1, 8'(8'h50 + i), '0);
    rd_op(4'h0);
    chk("txf_set", 32'(bus.bus_rdata & 8'h14), 32'h04);
    wr_op(4'h1, 8'h5f, '0);
    rd_op(4'h0);
    chk("txf_err", 32'(bus.bus_rdata & 8'h14), 32'h14);
    wr_op(4'h0, 8'h10, '0);
    wr_op(4'h1, 8'h60, 2'b01);
    rd_op(4'h0);
    chk("txf_pop_push", 32'(bus.bus_rdata & 8'h14), 32'h04);

    rd_op(4'hE);
    chk("unmapped_ack", 32'(bus.bus_ack), 32'h1);
    chk("unmapped_rdata", 32'(bus.bus_rdata), 32'h00);
    wr_op(4'hF, 8'hAA, '0);
    wr_op(4'hE, 8'h19, '0);
    rd_op(4'h0);

    idle('0, '0, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", 32'(dev_tx_valid), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    rd_op(4'h0);
    chk("rst_mid_csr0", 32'(bus.bus_rdata), 32'h20);

    for (int n = 0; n < 800; n++) begin
      op = $urandom_range(0, 9);
      a  = {3'($urandom_range(0, NCH - 1)), 1'b0};
      for (int c = 0; c < NCH; c++) begin
        rv[c] = ($urandom_range(0, 3) == 0);
        tr[c] = $urandom_range(0, 1) == 1;
      end
      case (op)
        2:       step(1, 0, a, 8'h00, rv, NCH*8'($urandom), tr);
        3, 4:    step(1, 0, a | 4'h1, 8'h00, rv, NCH*8'($urandom), tr);
        5:       step(0, 1, a, 8'($urandom), rv, NCH*8'($urandom), tr);
        6, 7:    step(0, 1, a | 4'h1, 8'($urandom), rv, NCH*8'($urandom), tr);
        8:       step(1, 1, a | 4'($urandom_range(0, 1)), 8'($urandom), rv, NCH*8'($urandom), tr);
        9:       step($urandom_range(0, 1) == 1, 1, 4'($urandom), 8'($urandom), rv,
                      NCH*8'($urandom), tr);
        default: step(0, 0, 4'h0, 8'h00, rv, NCH*8'($urandom), tr);
      endcase
    end
    idle('0, '0, '0);
    idle('0, '0, '0);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
